// File: rtl/mem_pkg.sv
// Shared types, default sizes and the march pattern for the memory BIST slice.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned RD_LAT_DEF = 1;

    // The pattern helper works at a fixed width; callers cast in and out.
    // DATA_W must not exceed PAT_DW, and ADDR_W must not exceed PAT_AW.
    localparam int unsigned PAT_DW = 64;
    localparam int unsigned PAT_AW = 32;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // P(a) = seed ^ zext(a) for pass 0, inverted for pass 1.
    function automatic logic [PAT_DW-1:0] pattern(
        input logic [PAT_DW-1:0] seed,
        input logic [PAT_AW-1:0] addr,
        input logic              pass
    );
        logic [PAT_DW-1:0] p;
        p = seed ^ PAT_DW'(addr);
        return pass ? ~p : p;
    endfunction

endpackage

// File: rtl/mem_bist_ctrl_if.sv
// Write/read port bundle between the BIST controller and the dual-port memory.
interface mem_bist_ctrl_if
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              Mem_wr_en;
    logic [ADDR_W-1:0] Mem_wr_addr;
    logic [DATA_W-1:0] Mem_wr_data;
    logic              Mem_rd_en;
    logic [ADDR_W-1:0] Mem_rd_addr;
    logic [DATA_W-1:0] Mem_rd_data;

    modport master (
        output Mem_wr_en, Mem_wr_addr, Mem_wr_data, Mem_rd_en, Mem_rd_addr,
        input  Mem_rd_data
    );

    modport slave (
        input  Mem_wr_en, Mem_wr_addr, Mem_wr_data, Mem_rd_en, Mem_rd_addr,
        output Mem_rd_data
    );

endinterface

// File: rtl/mem_bist_cmp.sv
// Read-latency alignment pipeline, comparator and error capture for the BIST.
module mem_bist_cmp
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_pass,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W+1:0] err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_pass,
    output logic              clean_c
);

    logic [RD_LAT-1:0] v_pipe;
    logic [ADDR_W-1:0] a_pipe [RD_LAT];
    logic              p_pipe [RD_LAT];
    logic [DATA_W-1:0] exp_c;
    logic              miss_c;

    // Carry {valid, addr, pass} alongside the memory's read latency.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            v_pipe <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                a_pipe[i] <= '0;
                p_pipe[i] <= 1'b0;
            end
        end else begin
            v_pipe[0] <= rd_en;
            a_pipe[0] <= rd_addr;
            p_pipe[0] <= rd_pass;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                v_pipe[i] <= v_pipe[i-1];
                a_pipe[i] <= a_pipe[i-1];
                p_pipe[i] <= p_pipe[i-1];
            end
        end
    end

    // Compare the returning word against the pattern for its address/pass.
    always_comb begin
        exp_c   = DATA_W'(pattern(PAT_DW'(seed), PAT_AW'(a_pipe[RD_LAT-1]), p_pipe[RD_LAT-1]));
        miss_c  = v_pipe[RD_LAT-1] && (rd_data != exp_c);
        clean_c = (err_count == '0) && !miss_c;
    end

    // Count every miscompare; remember only the first one of a run.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_pass <= 1'b0;
        end else if (clr) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_pass <= 1'b0;
        end else if (miss_c) begin
            err_count <= err_count + (ADDR_W+2)'(1);
            if (err_count == '0) begin
                first_err_addr <= a_pipe[RD_LAT-1];
                first_err_pass <= p_pipe[RD_LAT-1];
            end
        end
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Two-pass march BIST controller: sequences writes/reads and reports the result.
module mem_bist_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [DATA_W-1:0]     Seed,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Pass,
    output logic [ADDR_W+1:0]     Err_count,
    output logic [ADDR_W-1:0]     First_err_addr,
    output logic                  First_err_pass,
    mem_bist_ctrl_if.master       mem
);

    // RD_LAT is limited to 1..4, so a 2-bit drain counter is enough.
    localparam int unsigned CNT_W = 2;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic              addr_last;
    logic              pass_q;
    logic [CNT_W-1:0]  drain_cnt;
    logic [DATA_W-1:0] seed_q;
    logic              start_acc_c;
    logic              clean_c;

    function automatic logic [DATA_W-1:0] pat(
        input logic [DATA_W-1:0] s,
        input logic [ADDR_W-1:0] a,
        input logic              p
    );
        return DATA_W'(pattern(PAT_DW'(s), PAT_AW'(a), p));
    endfunction

    assign addr_nxt    = addr + ADDR_W'(1);
    assign addr_last   = &addr;
    assign start_acc_c = (state == IDLE) && Start;

    // Phase sequencer; every memory-side output is registered here.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state           <= IDLE;
            addr            <= '0;
            pass_q          <= 1'b0;
            drain_cnt       <= '0;
            seed_q          <= '0;
            Busy            <= 1'b0;
            Done            <= 1'b0;
            Pass            <= 1'b0;
            mem.Mem_wr_en   <= 1'b0;
            mem.Mem_wr_addr <= '0;
            mem.Mem_wr_data <= '0;
            mem.Mem_rd_en   <= 1'b0;
            mem.Mem_rd_addr <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        state           <= WRITE;
                        addr            <= '0;
                        pass_q          <= 1'b0;
                        seed_q          <= Seed;
                        Busy            <= 1'b1;
                        Pass            <= 1'b0;
                        mem.Mem_wr_en   <= 1'b1;
                        mem.Mem_wr_addr <= '0;
                        mem.Mem_wr_data <= pat(Seed, '0, 1'b0);
                    end
                end
                WRITE: begin
                    addr <= addr_nxt;
                    if (addr_last) begin
                        state           <= READ;
                        mem.Mem_wr_en   <= 1'b0;
                        mem.Mem_rd_en   <= 1'b1;
                        mem.Mem_rd_addr <= '0;
                    end else begin
                        mem.Mem_wr_addr <= addr_nxt;
                        mem.Mem_wr_data <= pat(seed_q, addr_nxt, pass_q);
                    end
                end
                READ: begin
                    addr <= addr_nxt;
                    if (addr_last) begin
                        state         <= DRAIN;
                        drain_cnt     <= '0;
                        mem.Mem_rd_en <= 1'b0;
                    end else begin
                        mem.Mem_rd_addr <= addr_nxt;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + CNT_W'(1);
                    if (drain_cnt == CNT_W'(RD_LAT - 1)) begin
                        if (!pass_q) begin
                            state           <= WRITE;
                            pass_q          <= 1'b1;
                            mem.Mem_wr_en   <= 1'b1;
                            mem.Mem_wr_addr <= '0;
                            mem.Mem_wr_data <= pat(seed_q, '0, 1'b1);
                        end else begin
                            // The last compare lands on this edge, so fold it in.
                            state <= DONE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            Pass  <= clean_c;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_cmp (
        .Clk            (Clk),
        .Rst            (Rst),
        .clr            (start_acc_c),
        .rd_en          (mem.Mem_rd_en),
        .rd_addr        (mem.Mem_rd_addr),
        .rd_pass        (pass_q),
        .seed           (seed_q),
        .rd_data        (mem.Mem_rd_data),
        .err_count      (Err_count),
        .first_err_addr (First_err_addr),
        .first_err_pass (First_err_pass),
        .clean_c        (clean_c)
    );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with behavioural dual-port memories (RD_LAT 1 and 2).
module tb_mem_bist_ctrl;

    localparam int N  = 16;
    localparam int L1 = 1;
    localparam int L2 = 2;

    typedef struct {
        int unsigned k;
        int unsigned lat;
        logic        pass;
        logic [5:0]  err;
        logic [3:0]  faddr;
        logic        fpass;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start1, start2;
    logic [31:0] seed1, seed2;
    logic        busy1, done1, pass1, fpass1;
    logic        busy2, done2, pass2, fpass2;
    logic [5:0]  err1, err2;
    logic [3:0]  faddr1, faddr2;

    mem_bist_ctrl_if #(.ADDR_W(4), .DATA_W(32)) m1 ();
    mem_bist_ctrl_if #(.ADDR_W(4), .DATA_W(32)) m2 ();

    mem_bist_ctrl #(.ADDR_W(4), .DATA_W(32), .RD_LAT(L1)) dut1 (
        .Clk(clk), .Rst(rst), .Start(start1), .Seed(seed1),
        .Busy(busy1), .Done(done1), .Pass(pass1), .Err_count(err1),
        .First_err_addr(faddr1), .First_err_pass(fpass1), .mem(m1)
    );

    mem_bist_ctrl #(.ADDR_W(4), .DATA_W(32), .RD_LAT(L2)) dut2 (
        .Clk(clk), .Rst(rst), .Start(start2), .Seed(seed2),
        .Busy(busy2), .Done(done2), .Pass(pass2), .Err_count(err2),
        .First_err_addr(faddr2), .First_err_pass(fpass2), .mem(m2)
    );

    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    exp_t        q1[$];
    exp_t        q2[$];
    logic        track1;
    int unsigned k1;
    logic [31:0] sseed1;
    logic        fault1, fault2;

    // Memory models: writes and reads on the rising edge, optional stuck-at-0 bit 0.
    logic [31:0] mem1 [N];
    logic [31:0] mem2 [N];
    logic [31:0] rd1, rd2a, rd2b;

    assign m1.Mem_rd_data = rd1;
    assign m2.Mem_rd_data = rd2b;

    always @(posedge clk) begin
        if (m1.Mem_wr_en)
            mem1[m1.Mem_wr_addr] <= (fault1 && m1.Mem_wr_addr == 4'd7) ? (m1.Mem_wr_data & ~32'h1) : m1.Mem_wr_data;
        if (m1.Mem_rd_en)
            rd1 <= mem1[m1.Mem_rd_addr];
        if (m2.Mem_wr_en)
            mem2[m2.Mem_wr_addr] <= (fault2 && m2.Mem_wr_addr == 4'd0) ? (m2.Mem_wr_data & ~32'h1) : m2.Mem_wr_data;
        if (m2.Mem_rd_en)
            rd2a <= mem2[m2.Mem_rd_addr];
        rd2b <= rd2a;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] tb_pat(input logic [31:0] s, input logic [3:0] a, input logic p);
        logic [31:0] v;
        v = s ^ {28'h0, a};
        return p ? ~v : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // DUT1 cycle-accurate port checker plus Done scoreboard.
    int   o1, ea1;
    logic ew1, er1, eb1, ep1;
    exp_t e1, e2;
    always @(negedge clk) begin
        check("wr_rd_disjoint1", 64'(m1.Mem_wr_en & m1.Mem_rd_en), 64'(0));
        if (track1) begin
            o1  = int'(cyc - k1) + 1;
            ew1 = (o1 >= 1 && o1 <= N) || (o1 >= 2*N+L1+1 && o1 <= 3*N+L1);
            er1 = (o1 >= N+1 && o1 <= 2*N) || (o1 >= 3*N+L1+1 && o1 <= 4*N+L1);
            eb1 = (o1 >= 1 && o1 <= 4*N+2*L1);
            ep1 = (o1 > 2*N+L1);
            check("busy1", 64'(busy1), 64'(eb1));
            check("wr_en1", 64'(m1.Mem_wr_en), 64'(ew1));
            check("rd_en1", 64'(m1.Mem_rd_en), 64'(er1));
            if (ew1) begin
                ea1 = ep1 ? o1 - (2*N+L1) - 1 : o1 - 1;
                check("wr_addr1", 64'(m1.Mem_wr_addr), 64'(ea1));
                check("wr_data1", 64'(m1.Mem_wr_data), 64'(tb_pat(sseed1, 4'(ea1), ep1)));
            end
            if (er1) begin
                ea1 = ep1 ? o1 - (3*N+L1) - 1 : o1 - N - 1;
                check("rd_addr1", 64'(m1.Mem_rd_addr), 64'(ea1));
            end
            if (o1 >= 4*N+2*L1+1) track1 = 1'b0;
        end
        if (done1) begin
            if (q1.size() == 0) begin
                check("done1_unexpected", 64'(done1), 64'(0));
            end else begin
                e1 = q1.pop_front();
                check("done1_cycle", 64'(int'(cyc - e1.k) + 1), 64'(e1.lat));
                check("done1_busy", 64'(busy1), 64'(0));
                check("pass1", 64'(pass1), 64'(e1.pass));
                check("err_count1", 64'(err1), 64'(e1.err));
                check("first_err_addr1", 64'(faddr1), 64'(e1.faddr));
                check("first_err_pass1", 64'(fpass1), 64'(e1.fpass));
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                check("done2_unexpected", 64'(done2), 64'(0));
            end else begin
                e2 = q2.pop_front();
                check("done2_cycle", 64'(int'(cyc - e2.k) + 1), 64'(e2.lat));
                check("pass2", 64'(pass2), 64'(e2.pass));
                check("err_count2", 64'(err2), 64'(e2.err));
                check("first_err_addr2", 64'(faddr2), 64'(e2.faddr));
                check("first_err_pass2", 64'(fpass2), 64'(e2.fpass));
            end
        end
    end

    task automatic chk_zero(input string tag);
        check({tag, "_busy"}, 64'(busy1), 64'(0));
        check({tag, "_done"}, 64'(done1), 64'(0));
        check({tag, "_pass"}, 64'(pass1), 64'(0));
        check({tag, "_err"}, 64'(err1), 64'(0));
        check({tag, "_faddr"}, 64'(faddr1), 64'(0));
        check({tag, "_fpass"}, 64'(fpass1), 64'(0));
        check({tag, "_wr_en"}, 64'(m1.Mem_wr_en), 64'(0));
        check({tag, "_wr_addr"}, 64'(m1.Mem_wr_addr), 64'(0));
        check({tag, "_wr_data"}, 64'(m1.Mem_wr_data), 64'(0));
        check({tag, "_rd_en"}, 64'(m1.Mem_rd_en), 64'(0));
        check({tag, "_rd_addr"}, 64'(m1.Mem_rd_addr), 64'(0));
        check({tag, "_busy2"}, 64'(busy2), 64'(0));
        check({tag, "_err2"}, 64'(err2), 64'(0));
    endtask

    // Launch a tracked DUT1 run; expected result goes onto the scoreboard.
    task automatic run1(input logic [31:0] s, input logic p, input logic [5:0] er,
                        input logic [3:0] fa, input logic fp);
        exp_t e;
        seed1  = s;
        sseed1 = s;
        start1 = 1'b1;
        k1     = cyc + 1;
        e = '{k: k1, lat: 4*N+2*L1+1, pass: p, err: er, faddr: fa, fpass: fp};
        q1.push_back(e);
        track1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        seed1  = $urandom;
    endtask

    task automatic run2(input logic [31:0] s, input logic p, input logic [5:0] er,
                        input logic [3:0] fa, input logic fp);
        exp_t e;
        seed2  = s;
        start2 = 1'b1;
        e = '{k: cyc + 1, lat: 4*N+2*L2+1, pass: p, err: er, faddr: fa, fpass: fp};
        q2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
        seed2  = $urandom;
    endtask

    task automatic wait_q(input int which);
        int n;
        n = 0;
        while (((which == 1) ? q1.size() : q2.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 64'((which == 1) ? q1.size() : q2.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        track1 = 1'b0;
        fault1 = 1'b0;
        fault2 = 1'b0;
        rst    = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        seed1  = '0;
        seed2  = '0;

        // Reset held with random Start/Seed activity.
        repeat (5) begin
            @(negedge clk);
            start1 = 1'($urandom_range(0, 1));
            start2 = 1'($urandom_range(0, 1));
            seed1  = $urandom;
            seed2  = $urandom;
            #1 chk_zero("rst_hold");
        end
        start1 = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("idle");

        // Fault-free run.
        run1(32'hA5A5A5A5, 1'b1, 6'd0, 4'd0, 1'b0);
        wait_q(1);
        check("pass_hold", 64'(pass1), 64'(1));

        // Stuck-at-0 on bit 0 of address 7: only pass 1 sees it.
        fault1 = 1'b1;
        run1(32'hA5A5A5A5, 1'b0, 6'd1, 4'd7, 1'b1);
        wait_q(1);
        check("fail_hold", 64'(pass1), 64'(0));
        fault1 = 1'b0;

        // Start pulses mid-run are ignored.
        run1(32'h3C3C0F0F, 1'b1, 6'd0, 4'd0, 1'b0);
        while (int'(cyc - k1) + 1 != 5) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (int'(cyc - k1) + 1 != 40) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_q(1);

        // Asynchronous reset while pass 0 writes address 5.
        seed1  = 32'hDEADBEEF;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!(m1.Mem_wr_en && m1.Mem_wr_addr == 4'd5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_addr5", 64'(m1.Mem_wr_addr), 64'(5));
        #2 rst = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        chk_zero("rst_mid");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run1(32'h0F0F1234, 1'b1, 6'd0, 4'd0, 1'b0);
        wait_q(1);

        // RD_LAT=2 build: fault-free, then a pass-0 fault at address 0.
        run2(32'hA5A5A5A5, 1'b1, 6'd0, 4'd0, 1'b0);
        wait_q(2);
        fault2 = 1'b1;
        run2(32'hA5A5A5A5, 1'b0, 6'd1, 4'd0, 1'b0);
        wait_q(2);
        fault2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bist_ctrl.md
# mem_bist_ctrl

- Built-in self-test controller that drives both ports of `dual_port_memory`: the write port (Wr_en/Wr_addr/Data_in) and the read port (Rd_en/Rd_addr/Data_out).
- On a Start pulse it runs a two-pass march: write pattern, read and compare, write inverted pattern, read and compare.
- Reports pass/fail, error count and first failing location.
- Sits beside the memory and replaces bench-driven stimulus for power-on and self-check.

## Interface
Parameters:
- ADDR_W, 4, memory address width; N = 2^ADDR_W locations
- DATA_W, 32, memory data width
- RD_LAT, 1, clock cycles from the Clk edge that samples Mem_rd_en=1 to valid Mem_rd_data; range 1..4

Ports:
- Clk  input  1  system clock; all logic on rising edge
- Rst  input  1  reset, asynchronous, active-low
- Start  input  1  one-cycle request; honoured only in IDLE
- Seed  input  DATA_W  pattern seed, latched on accepted Start
- Busy  output  1  high from the cycle after an accepted Start through the last DRAIN cycle
- Done  output  1  one-cycle pulse at test completion
- Pass  output  1  1 = no miscompares; valid from Done until the next accepted Start
- Err_count  output  ADDR_W+2  total miscompares across both passes; cannot overflow (max 2N)
- First_err_addr  output  ADDR_W  address of the first miscompare
- First_err_pass  output  1  pass (0/1) of the first miscompare
- Mem_wr_en  output  1  to memory Wr_en
- Mem_wr_addr  output  ADDR_W  to memory Wr_addr
- Mem_wr_data  output  DATA_W  to memory Data_in
- Mem_rd_en  output  1  to memory Rd_en
- Mem_rd_addr  output  ADDR_W  to memory Rd_addr
- Mem_rd_data  input  DATA_W  from memory Data_out

## Operation
- Pattern: P(a) = Seed_q XOR zero_extend(a).
  - Pass 0 writes and expects P(a).
  - Pass 1 writes and expects ~P(a).
- States:
  - IDLE -> WRITE on Start.
  - WRITE (N cycles, addr 0..N-1) -> READ.
  - READ (N cycles, addr 0..N-1) -> DRAIN.
  - DRAIN (RD_LAT cycles) -> WRITE with pass=1 if pass=0, else DONE.
  - DONE (1 cycle, Done=1) -> IDLE.
- Address counter is ADDR_W wide and wraps from N-1 to 0 at each phase end; phase change is on the wrap.
- Compare pipeline: an RD_LAT-deep shift register carries {valid, addr, pass}.
  - The compare fires when valid emerges.
  - A miscompare is Mem_rd_data != expected(addr, pass).
- Error capture:
  - Every miscompare increments Err_count.
  - The first miscompare of a run captures First_err_addr and First_err_pass.
  - Pass = (Err_count==0) at DONE.
- On an accepted Start, Err_count, First_err_* and Pass clear, and Seed is latched.
- Start while Busy or in DONE is ignored, with no effect on the run.
- Mem_wr_en and Mem_rd_en are never both high; write and read phases are disjoint.
- Reset (Rst=0), at any time:
  - State returns to IDLE immediately and the compare pipeline clears.
  - All outputs go to 0.
  - Memory contents are left undefined; a new Start runs a full test.

## Timing
- Reset values: Busy, Done, Pass, Err_count, First_err_*, and all Mem_* outputs are 0.
- Start sampled at edge k:
  - Mem_wr_en=1, Mem_wr_addr=0 in cycle k+1.
  - Pass-0 writes occupy cycles k+1..k+N.
  - Pass-0 reads occupy k+N+1..k+2N.
  - Drain follows for RD_LAT cycles.
  - Pass 1 repeats the same sequence.
- Done is high in cycle k+4N+2*RD_LAT+1; Busy is low in that cycle.
  - N=16, RD_LAT=1: Done at k+67.
- Err_count and First_err_* are stable no later than the cycle Done is high.
- Mem_* outputs are registered; no combinational path from Mem_rd_data to any output.

## Structure
- Shared package mem_pkg holds:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE)
  - default ADDR_W, DATA_W, RD_LAT
  - pattern function P(seed, addr, pass)
- Sub-module mem_bist_cmp: the RD_LAT compare pipeline, the comparator and the error-capture registers.
- The top holds the FSM and address/pass counters.

## Test plan
- Reset: hold Rst=0 with random Start/Seed -> every output 0; Start is ignored while in reset.
- Fault-free memory model, Seed=32'hA5A5A5A5, Start at edge k:
  - Pass 0 writes addr 3 with 32'hA5A5A5A6.
  - Pass 1 writes addr 3 with 32'h5A5A5A59.
  - Done at k+67, Pass=1, Err_count=0.
- Stuck-at-0 on bit 0 of addr 7, same Seed:
  - Pass 0 expects A5A5A5A2 and passes.
  - Pass 1 expects 5A5A5A5D and reads 5A5A5A5C.
  - Err_count=1, First_err_addr=7, First_err_pass=1, Pass=0.
- Start pulsed at cycles k+5 and k+40 during a run -> ignored; Done is still at k+67 and results are unchanged.
- Rst=0 while Mem_wr_addr=5 in pass 0 -> all outputs 0 asynchronously; a later Start runs the full 67 cycles with a correct result.
- RD_LAT=2 build with a matching memory model -> Done at k+69, Pass=1; the first compare fires 2 cycles after the first read.
